// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences ALU, memory port,
// instruction register and register file across several cycles per instruction.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALU_op,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Mux select encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] A_PC       = 2'b00;
  localparam logic [1:0] A_OLDPC    = 2'b01;
  localparam logic [1:0] A_RS1      = 2'b10;
  localparam logic [1:0] B_RS2      = 2'b00;
  localparam logic [1:0] B_IMM      = 2'b01;
  localparam logic [1:0] B_FOUR     = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_FUNCT   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic is_lw;
  logic is_sw;
  logic is_r;
  logic is_i;
  logic is_beq;
  logic is_jal;

  logic pc_update;
  logic branch;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;
  logic illegal_raw;

  // Opcode class flags shared by the next-state logic and the immediate decode
  always_comb begin
    is_lw  = (opcode == OP_LW);
    is_sw  = (opcode == OP_SW);
    is_r   = (opcode == OP_R);
    is_i   = (opcode == OP_I);
    is_beq = (opcode == OP_BEQ);
    is_jal = (opcode == OP_JAL);
  end

  // State register; reset returns to FETCH asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d       = S_FETCH;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = A_PC;
    alu_src_b     = B_RS2;
    ALU_op        = OP_ADD;
    illegal_raw   = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;

    case (state_q)
      S_FETCH: begin
        adr_src      = 1'b0;
        alu_src_a    = A_PC;
        alu_src_b    = B_FOUR;
        ALU_op       = OP_ADD;
        result_src   = RES_ALURES;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
        state_d      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Old PC + immediate: branch target parked in the ALU out register
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        ALU_op    = OP_ADD;
        if (is_lw || is_sw) begin
          state_d = S_MEMADR;
        end else if (is_r) begin
          state_d = S_EXECR;
        end else if (is_i) begin
          state_d = S_EXECI;
        end else if (is_beq) begin
          state_d = S_BEQ;
        end else if (is_jal) begin
          state_d = S_JAL;
        end else begin
          illegal_raw = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        ALU_op    = OP_ADD;
        if (is_lw) begin
          state_d = S_MEMREAD;
        end else if (is_sw) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWRITE: begin
        // Strobe stays up while the port stalls
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        ALU_op    = OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        ALU_op    = OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src    = RES_ALUOUT;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQ: begin
        // rs1 - rs2 sets zero; PC takes the target computed in DECODE
        alu_src_a  = A_RS1;
        alu_src_b  = B_RS2;
        ALU_op     = OP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC <= target, while old PC + 4 becomes the link value
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_FOUR;
        ALU_op     = OP_ADD;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        state_d    = S_ALUWB;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Immediate format from the opcode alone
  always_comb begin
    imm_src = 2'b00;
    if (is_sw) begin
      imm_src = 2'b01;
    end else if (is_beq) begin
      imm_src = 2'b10;
    end else if (is_jal) begin
      imm_src = 2'b11;
    end
  end

  // Write enables and the illegal pulse are held low while in reset
  always_comb begin
    pc_write  = rst_n & (pc_update | (branch & zero));
    ir_write  = rst_n & ir_write_raw;
    mem_write = rst_n & mem_write_raw;
    reg_write = rst_n & reg_write_raw;
    illegal   = rst_n & illegal_raw;
  end

  assign state = STATE_W'(state_q);

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core. It sequences the shared ALU, memory port, instruction register and register file over several cycles per instruction. It drives the 2-bit ALU operation class into the ALU decoder, which resolves `funct3`/`funct7` into the final ALU control. It also inserts wait states on the unified memory port via a ready handshake.

## Interface
- No parameters; the state encoding is fixed (see Operation).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  `instr[6:0]` from the instruction register; valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory port completes the current access this cycle.
- `pc_write`  out  1  PC register enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  instruction register and old-PC enable.
- `reg_write`  out  1  register file write enable.
- `result_src`  out  2  result mux select: 00 = ALU out register, 01 = data register, 10 = ALU result.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1 data.
- `alu_src_b`  out  2  ALU B select: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- `ALU_op`  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = decode by `funct3`/`funct7`.
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `illegal`  out  1  one-cycle pulse when an unsupported opcode is seen in DECODE.
- `state`  out  4  current state, for debug and verification.

## Operation
- States and encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
  - EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10
  - Codes 11–15 are unreachable; if entered, go to FETCH on the next edge.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Transitions:
  - FETCH → DECODE when `mem_ready` = 1; otherwise hold.
  - DECODE → MEMADR for lw/sw, EXECR for R-type, EXECI for I-ALU, BEQ for beq, JAL for jal. Any other opcode → FETCH with `illegal` = 1.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB when `mem_ready` = 1; otherwise hold.
  - MEMWRITE → FETCH when `mem_ready` = 1; otherwise hold.
  - MEMWB → FETCH.
  - EXECR, EXECI and JAL → ALUWB.
  - ALUWB → FETCH.
  - BEQ → FETCH.
- Outputs are Moore, decoded from `state`. Any signal not listed for a state is 0.
  - FETCH: `adr_src` = 0, `alu_src_a` = 00, `alu_src_b` = 10, `ALU_op` = 00, `result_src` = 10, `ir_write` = `mem_ready`, pc_update = `mem_ready`.
  - DECODE: `alu_src_a` = 01, `alu_src_b` = 01, `ALU_op` = 00 (computes the branch target).
  - MEMADR: `alu_src_a` = 10, `alu_src_b` = 01, `ALU_op` = 00.
  - MEMREAD: `adr_src` = 1.
  - MEMWRITE: `adr_src` = 1, `mem_write` = 1 for every cycle held.
  - MEMWB: `result_src` = 01, `reg_write` = 1.
  - EXECR: `alu_src_a` = 10, `alu_src_b` = 00, `ALU_op` = 10.
  - EXECI: `alu_src_a` = 10, `alu_src_b` = 01, `ALU_op` = 10.
  - ALUWB: `result_src` = 00, `reg_write` = 1.
  - BEQ: `alu_src_a` = 10, `alu_src_b` = 00, `ALU_op` = 01, `result_src` = 00, branch = 1.
  - JAL: `alu_src_a` = 01, `alu_src_b` = 10, `ALU_op` = 00, `result_src` = 00, pc_update = 1.
- `pc_write` = pc_update | (branch & `zero`). This is the only output depending on `zero`.
- `imm_src` is purely combinational from `opcode`, independent of state:
  - lw and I-ALU → 00; sw → 01; beq → 10; jal → 11; any other opcode → 00.

## Timing
- Asynchronous reset: `state` is forced to FETCH immediately on `rst_n` falling.
- While `rst_n` = 0, `pc_write`, `ir_write`, `mem_write`, `reg_write` and `illegal` are forced to 0. Mux selects show FETCH values.
- After `rst_n` rises, the first FETCH is evaluated on the first edge.
- Reset mid-instruction aborts the instruction. No partial write occurs after `rst_n` falls.
- Cycle counts with `mem_ready` tied to 1:
  - lw 5; sw 4; R-type and I-ALU 4; jal 4; beq 3; illegal opcode 2.
- Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- `illegal` is high only in the DECODE cycle and is never asserted for two consecutive cycles.
- `mem_ready` is ignored in all states except FETCH, MEMREAD and MEMWRITE.

## Test plan
- Reset then R-type with `mem_ready` = 1:
  - `state` reads 0, 1, 6, 8, 0.
  - `ALU_op` = 10 in EXECR; `reg_write` high only in ALUWB; `pc_write` high only in FETCH.
- lw with `mem_ready` low for 2 cycles in FETCH and 1 cycle in MEMREAD:
  - `state` reads 0, 0, 0, 1, 2, 3, 3, 4, 0 (9 cycles).
  - `ir_write` is high for one cycle only.
- sw:
  - `imm_src` = 01; `mem_write` = 1 with `adr_src` = 1 in MEMWRITE only; `reg_write` never asserted.
- beq with `zero` = 1, then again with `zero` = 0:
  - `pc_write` = 1 in BEQ for the first case and 0 for the second.
  - `ALU_op` = 01 and `imm_src` = 10 in both.
- jal:
  - States 0, 1, 10, 8, 0; `pc_write` = 1 in JAL; `imm_src` = 11.
- Illegal opcode 0000000:
  - `illegal` pulses once in DECODE, then FETCH; no enable is asserted.
- Reset mid-instruction:
  - `rst_n` dropped mid-MEMWRITE: `mem_write` falls immediately and `state` = 0 asynchronously.
